// File: rtl/mclk_freq_meter.sv
`timescale 1ps/1ps
// mclk_freq_meter: counts synchronised rising edges of sig_in over a fixed gate
// of clk cycles and reports the count with in-range and no-signal flags.
module mclk_freq_meter #(
    parameter int unsigned GATE_CYCLES = 50000,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EXP_MIN     = 11280,
    parameter int unsigned EXP_MAX     = 11300,
    parameter bit          CONTINUOUS  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             in_range,
    output logic             no_signal
);

    localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    // Range compare is done at least 32 bits wide so EXP_MIN/EXP_MAX are never truncated
    localparam int unsigned XW = (CNT_W > 32) ? CNT_W : 32;
    localparam logic [XW-1:0] EXP_MIN_X = XW'(EXP_MIN);
    localparam logic [XW-1:0] EXP_MAX_X = XW'(EXP_MAX);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_REPORT  = 2'd2;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [1:0]             r_state;
    logic [GW-1:0]          r_gate_cnt;
    logic [CNT_W-1:0]       r_edge_cnt;
    logic                   r_busy;
    logic [CNT_W-1:0]       r_count;
    logic                   r_valid;
    logic                   r_in_range;
    logic                   r_no_signal;

    logic                   w_rise;
    logic                   w_go;
    logic [XW-1:0]          w_cnt_ext;
    logic                   w_cnt_in_range;

    assign w_rise         = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_go           = start | CONTINUOUS;
    assign w_cnt_ext      = XW'(r_edge_cnt);
    assign w_cnt_in_range = (w_cnt_ext >= EXP_MIN_X) && (w_cnt_ext <= EXP_MAX_X);

    // Synchroniser and edge register run in every state so MEASURE never sees a stale edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Measurement FSM with gate counter and saturating edge counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state    <= S_MEASURE;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_MEASURE: begin
                    r_gate_cnt <= r_gate_cnt + 1'b1;
                    if (w_rise && (r_edge_cnt != '1)) begin
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                    end
                    if (r_gate_cnt == GATE_LAST) begin
                        r_state <= S_REPORT;
                        r_busy  <= 1'b0;
                    end
                end
                S_REPORT: begin
                    if (w_go) begin
                        r_state    <= S_MEASURE;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Report registers: latched once per gate, valid pulses for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_in_range  <= 1'b0;
            r_no_signal <= 1'b0;
        end else begin
            r_valid <= (r_state == S_REPORT);
            if (r_state == S_REPORT) begin
                r_count     <= r_edge_cnt;
                r_in_range  <= w_cnt_in_range;
                r_no_signal <= (r_edge_cnt == '0);
            end
        end
    end

    assign busy        = r_busy;
    assign count_out   = r_count;
    assign count_valid = r_valid;
    assign in_range    = r_in_range;
    assign no_signal   = r_no_signal;

endmodule
